seq_alu: RTL and testbench

//  Parametrised, multi-cycle successor to the datapath ALU. It keeps the carry (sc) and

---
 rtl/seq_alu.sv | 173 +++++++++++++++++
 tb/tb_seq_alu.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU with internal carry/parity flags, N-bit shifts and shift-add multiply.
// Valid/ready handshakes on command and result so the controller can stall it.
module seq_alu #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_cmd,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rslt,
  output logic             sc_flag,
  output logic             pari_flag,
  output logic             busy
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SHL1 = 4'd2;
  localparam logic [3:0] OP_ASR1 = 4'd3;
  localparam logic [3:0] OP_RRC  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_RXOR = 4'd8;
  localparam logic [3:0] OP_SHLN = 4'd9;
  localparam logic [3:0] OP_SHRN = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_CLRF = 4'd12;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [3:0]       cmd_q;
  logic [WIDTH-1:0] opa, hi, lo;
  logic             accept, is_mul, multi;
  logic [SW-1:0]    shamt;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             step_c;

  // Result of every op that completes on the accept edge, packed as {pari, sc, rslt}.
  function automatic logic [WIDTH+1:0] single_op(
    input logic [3:0]       cmd,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             sc,
    input logic             pari
  );
    logic [WIDTH:0] sum;
    logic           np;
    sum = '0;
    np  = 1'b0;
    single_op = {pari, sc, {WIDTH{1'b0}}};
    case (cmd)
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, sc};
        single_op = {1'b0, sum};
      end
      OP_SUB: begin
        sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, sc};
        single_op = {1'b0, sum};
      end
      OP_SHL1: single_op = {pari, a[WIDTH-1], a[WIDTH-2:0], sc};
      OP_ASR1: single_op = {pari, a[0], a[WIDTH-1], a[WIDTH-1:1]};
      OP_RRC:  single_op = {pari, a[0], sc, a[WIDTH-1:1]};
      OP_NOT:  single_op = {pari, 1'b0, ~a};
      OP_AND:  single_op = {pari, 1'b0, a & b};
      OP_XOR:  single_op = {pari, 1'b0, a ^ b};
      OP_RXOR: begin
        np = (^a) ^ pari;
        single_op = {np, 1'b0, {(WIDTH-1){1'b0}}, np};
      end
      // Only reached with a zero shift amount: pass A through, carry untouched.
      OP_SHLN, OP_SHRN: single_op = {pari, sc, a};
      OP_CLRF: single_op = '0;
      default: ;
    endcase
  endfunction

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign accept    = in_valid && in_ready;
  assign shamt     = in_b[SW-1:0];
  assign is_mul    = MUL_EN && (alu_cmd == OP_MUL);
  assign multi     = is_mul || (((alu_cmd == OP_SHLN) || (alu_cmd == OP_SHRN)) && (shamt != '0));

  // One EXEC step: single-bit shift, or one add-and-shift of the multiply.
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opa} : {(WIDTH+1){1'b0}});
    step_hi = hi;
    step_lo = lo;
    step_c  = 1'b0;
    case (cmd_q)
      OP_SHLN: begin
        step_lo = {lo[WIDTH-2:0], 1'b0};
        step_c  = lo[WIDTH-1];
      end
      OP_SHRN: begin
        step_lo = {1'b0, lo[WIDTH-1:1]};
        step_c  = lo[0];
      end
      default: begin
        step_hi = mul_sum[WIDTH:1];
        step_lo = {mul_sum[0], lo[WIDTH-1:1]};
        step_c  = |mul_sum[WIDTH:1];
      end
    endcase
  end

  // Control, result and flag registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rslt      <= '0;
      sc_flag   <= 1'b0;
      pari_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (multi) begin
              state <= S_EXEC;
              cnt   <= is_mul ? CW'(WIDTH) : {1'b0, shamt};
            end else begin
              state <= S_DONE;
              {pari_flag, sc_flag, rslt} <= single_op(alu_cmd, in_a, in_b, sc_flag, pari_flag);
            end
          end
        end
        S_EXEC: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state   <= S_DONE;
            rslt    <= step_lo;
            sc_flag <= step_c;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand working registers; lo holds the shift value or the multiplier.
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_q <= alu_cmd;
      opa   <= in_a;
      hi    <= '0;
      lo    <= (alu_cmd == OP_MUL) ? in_b : in_a;
    end else if (state == S_EXEC) begin
      hi <= step_hi;
      lo <= step_lo;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu (WIDTH=8): directed steps then random commands against an arithmetic model.
module tb_seq_alu;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alu_cmd = 4'd0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] rslt;
  logic         sc_flag;
  logic         pari_flag;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int m_sc = 0;
  int m_pari = 0;
  int cap_r, cap_sc, cap_p, cap_lat;

  seq_alu #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_cmd(alu_cmd), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .rslt(rslt), .sc_flag(sc_flag), .pari_flag(pari_flag),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: flags as integers, results from plain arithmetic on 8-bit values.
  task automatic model(input int cmd, input int a, input int b, output int er, output int lat);
    int t, n;
    n = b % 8;
    lat = 1;
    er = 0;
    case (cmd)
      0:  begin t = a + b + m_sc;         er = t % 256; m_sc = t / 256; m_pari = 0; end
      1:  begin t = a + (255 - b) + m_sc; er = t % 256; m_sc = t / 256; m_pari = 0; end
      2:  begin t = a * 2 + m_sc;         er = t % 256; m_sc = t / 256; end
      3:  begin er = a / 2 + (a >= 128 ? 128 : 0); m_sc = a % 2; end
      4:  begin er = a / 2 + m_sc * 128;          m_sc = a % 2; end
      5:  begin er = 255 - a; m_sc = 0; end
      6:  begin er = a & b;   m_sc = 0; end
      7:  begin er = a ^ b;   m_sc = 0; end
      8:  begin m_pari = ($countones(a) + m_pari) % 2; er = m_pari; m_sc = 0; end
      9:  begin
            t = a * (1 << n); er = t % 256;
            if (n != 0) begin m_sc = (t / 256) % 2; lat = n + 1; end
          end
      10: begin
            er = a / (1 << n);
            if (n != 0) begin m_sc = (a / (1 << (n - 1))) % 2; lat = n + 1; end
          end
      11: begin t = a * b; er = t % 256; m_sc = (t >= 256) ? 1 : 0; lat = W + 1; end
      12: begin er = 0; m_sc = 0; m_pari = 0; end
      default: er = 0;
    endcase
  endtask

  task automatic run_op(input int cmd, input int a, input int b, input int hold);
    int er, lat, cyc;
    logic [W-1:0] r0;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    alu_cmd   = cmd[3:0];
    in_a      = a[W-1:0];
    in_b      = b[W-1:0];
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    model(cmd, a, b, er, lat);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    if (lat > 1) begin
      chk("busy_exec", {in_ready, busy}, 2'b01);
      alu_cmd  = 4'd12;
      in_a     = ~in_a;
      in_b     = ~in_b;
      in_valid = 1'b1;
      @(negedge clk);
      cyc = 2;
      in_valid = 1'b0;
    end
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    cap_lat = cyc;
    cap_r   = int'(rslt);
    cap_sc  = int'(sc_flag);
    cap_p   = int'(pari_flag);
    chk("latency", cyc, lat);
    chk("rslt", rslt, er);
    chk("sc", sc_flag, m_sc);
    chk("pari", pari_flag, m_pari);
    if (hold > 0) begin
      r0 = rslt;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_hs", {out_valid, in_ready}, 2'b10);
        chk("hold_rslt", rslt, r0);
        chk("hold_sc", sc_flag, m_sc);
      end
      out_ready = 1'b1;
    end
  endtask

  initial begin
    int cmd, a, b, h;
    repeat (2) @(negedge clk);
    chk("rst_rslt", rslt, 0);
    chk("rst_flags", {sc_flag, pari_flag}, 2'b00);
    chk("rst_hs", {out_valid, in_ready, busy}, 3'b010);
    reset_n = 1'b1;

    // Add with carry chain
    run_op(12, 0, 0, 0);
    run_op(0, 'hFF, 'h01, 0);
    chk("t1_r", cap_r, 'h00); chk("t1_sc", cap_sc, 1); chk("t1_lat", cap_lat, 1);
    run_op(0, 'h10, 'h20, 0);
    chk("t1b_r", cap_r, 'h31); chk("t1b_sc", cap_sc, 0);

    // Subtract, carry meaning no-borrow
    run_op(0, 'hFF, 'h01, 0);
    run_op(1, 'h07, 'h05, 0);
    chk("t2_r", cap_r, 'h02); chk("t2_sc", cap_sc, 1);
    run_op(1, 'h05, 'h07, 0);
    chk("t2b_r", cap_r, 'hFE); chk("t2b_sc", cap_sc, 0);

    // Multi-bit shift and the zero-amount shortcut
    run_op(9, 'h81, 3, 0);
    chk("t3_r", cap_r, 'h08); chk("t3_sc", cap_sc, 0); chk("t3_lat", cap_lat, 4);
    run_op(9, 'h81, 0, 0);
    chk("t3b_r", cap_r, 'h81); chk("t3b_lat", cap_lat, 1);
    run_op(10, 'h81, 1, 0);
    chk("t3c_r", cap_r, 'h40); chk("t3c_sc", cap_sc, 1);

    // Multiply and overflow flag
    run_op(11, 'h0D, 'h0B, 0);
    chk("t4_r", cap_r, 'h8F); chk("t4_sc", cap_sc, 0); chk("t4_lat", cap_lat, 9);
    run_op(11, 'h10, 'h10, 0);
    chk("t4b_r", cap_r, 'h00); chk("t4b_sc", cap_sc, 1);

    // Running parity
    run_op(12, 0, 0, 0);
    run_op(8, 'h07, 0, 0); chk("t5a", {cap_p[0], cap_r[7:0]}, 9'h101);
    run_op(8, 'h03, 0, 0); chk("t5b", {cap_p[0], cap_r[7:0]}, 9'h101);
    run_op(8, 'h01, 0, 0); chk("t5c", {cap_p[0], cap_r[7:0]}, 9'h000);

    // Consumer stall, then reset in the middle of a multiply
    run_op(7, 'h5A, 'h0F, 5);
    chk("t6_r", cap_r, 'h55);
    run_op(11, 'hC3, 'h35, 3);
    run_op(8, 'h01, 0, 0);
    run_op(2, 'h80, 0, 0);
    chk("t6_flags", {cap_sc[0], cap_p[0]}, 2'b11);
    @(negedge clk);
    alu_cmd = 4'd11; in_a = 8'hFF; in_b = 8'hFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("t6_rst_hs", {out_valid, in_ready}, 2'b01);
    chk("t6_rst_flags", {sc_flag, pari_flag}, 2'b00);
    chk("t6_rst_rslt", rslt, 0);
    m_sc = 0;
    m_pari = 0;

    // Random commands, including reserved codes and occasional stalls
    for (int k = 0; k < 300; k++) begin
      cmd = int'($urandom_range(0, 15));
      a   = int'($urandom_range(0, 255));
      b   = int'($urandom_range(0, 255));
      h   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(cmd, a, b, h);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
